// File: rtl/ysyx_23060042_mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, transaction owner
// and the request payload that is held stable toward memory.
package ysyx_23060042_mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_MASK_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  wen;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_MASK_W-1:0] wmask;
    } req_t;

endpackage

// File: rtl/ysyx_23060042_mem_arb_sel.sv
// Combinational grant selector. Fixed LSU-over-IFU priority by default;
// round-robin on ties when YSYX_23060042_MEM_ARB_RR_EN is defined.
module ysyx_23060042_mem_arb_sel
    import ysyx_23060042_mem_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    // On a tie the round-robin build hands the grant to whoever did not win last
    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant       = OWN_IFU;
`ifdef YSYX_23060042_MEM_ARB_RR_EN
        if (ifu_valid && lsu_valid) begin
            grant = (last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (lsu_valid) begin
            grant = OWN_LSU;
        end
`else
        if (lsu_valid) begin
            grant = OWN_LSU;
        end
`endif
    end

`ifndef YSYX_23060042_MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ysyx_23060042_mem_arb.sv
// Single-outstanding IFU/LSU arbiter in front of the one memory port.
// Define YSYX_23060042_MEM_ARB_RR_EN to build round-robin tie breaking.
module ysyx_23060042_mem_arb
    import ysyx_23060042_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                arb_busy
);

    state_t            state;
    state_t            state_next;
    owner_t            owner_q;
    req_t              payload_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant;
    logic              grant_valid;
    logic              last_grant;
    logic              accept;
    logic              owner_resp_ready;

    // The history register only exists when tie breaking needs it
`ifdef YSYX_23060042_MEM_ARB_RR_EN
    owner_t last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_IFU;
        end else if (accept) begin
            last_grant_q <= owner_t'(grant);
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = OWN_IFU;
`endif

    ysyx_23060042_mem_arb_sel u_sel (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign accept           = (state == IDLE) && grant_valid && !rst;
    assign owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)           state_next = REQ;
            REQ:     if (mem_req_ready)    state_next = WAIT;
            WAIT:    if (mem_resp_valid)   state_next = RESP;
            RESP:    if (owner_resp_ready) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Fetches carry no store data, so their write fields are latched as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_IFU;
            payload_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                owner_q <= owner_t'(grant);
                if (grant == OWN_LSU) begin
                    payload_q <= '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
                end else begin
                    payload_q <= '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
                end
            end
            if ((state == WAIT) && mem_resp_valid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                ifu_req_ready = accept && (grant == OWN_IFU);
                lsu_req_ready = accept && (grant == OWN_LSU);
            end
            REQ:  mem_req_valid  = 1'b1;
            WAIT: mem_resp_ready = 1'b1;
            RESP: begin
                ifu_resp_valid = (owner_q == OWN_IFU);
                lsu_resp_valid = (owner_q == OWN_LSU);
            end
            default: ;
        endcase
    end

    assign arb_busy  = (state != IDLE);
    assign mem_addr  = payload_q.addr;
    assign mem_wen   = payload_q.wen;
    assign mem_wdata = payload_q.wdata;
    assign mem_wmask = payload_q.wmask;
    assign ifu_rdata = rdata_q;
    assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_23060042_mem_arb.sv
// Bench for ysyx_23060042_mem_arb: directed scenarios followed by randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_ysyx_23060042_mem_arb;

`ifdef YSYX_23060042_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        arb_busy;

    typedef struct packed {
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        lw;
        logic [31:0] ld;
        logic [3:0]  lm;
        logic        mrq;
        logic        mrv;
        logic [31:0] mrd;
        logic        irr;
        logic        lrr;
    } stim_t;

    stim_t s;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    ysyx_23060042_mem_arb dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_rdata      (mem_rdata),
        .arb_busy       (arb_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs and lets combinational outputs settle
    task automatic applyStimulus(input stim_t st);
        ifu_req_valid  = st.iv;
        ifu_addr       = st.ia;
        lsu_req_valid  = st.lv;
        lsu_addr       = st.la;
        lsu_wen        = st.lw;
        lsu_wdata      = st.ld;
        lsu_wmask      = st.lm;
        mem_req_ready  = st.mrq;
        mem_resp_valid = st.mrv;
        mem_rdata      = st.mrd;
        ifu_resp_ready = st.irr;
        lsu_resp_ready = st.lrr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference state for the random phase
    bit          m_ifu_pend, m_lsu_pend, m_lsu_w;
    logic [31:0] m_ifu_a, m_lsu_a, m_lsu_d;
    logic [3:0]  m_lsu_m;
    bit          m_busy, m_macc, m_rpend, m_own_lsu, m_last_lsu;
    logic [31:0] e_addr, e_wdata, e_data, mem_data;
    bit          e_wen;
    logic [3:0]  e_wmask;
    int          mem_delay;
    bit          grant, win_lsu;

    initial begin
        // Reset state
        s = '0;
        rst = 1'b1;
        applyStimulus(s);
        tick;
        tick;
        rst = 1'b0;
        applyStimulus(s);
        checkOutput("rst_busy", arb_busy, 32'd0);
        checkOutput("rst_mreqv", mem_req_valid, 32'd0);
        checkOutput("rst_mrespr", mem_resp_ready, 32'd0);
        checkOutput("rst_maddr", mem_addr, 32'd0);
        checkOutput("rst_rdata", ifu_rdata, 32'd0);
        checkOutput("rst_respv", {ifu_resp_valid, lsu_resp_valid}, 32'd0);

        // Lone IFU fetch at minimum latency
        s.iv = 1'b1; s.ia = 32'h8000_0000; s.mrq = 1'b1;
        applyStimulus(s);
        checkOutput("t1_ifu_rdy", ifu_req_ready, 32'd1);
        checkOutput("t1_lsu_rdy", lsu_req_ready, 32'd0);
        tick;
        s.iv = 1'b0;
        applyStimulus(s);
        checkOutput("t1_mreqv", mem_req_valid, 32'd1);
        checkOutput("t1_maddr", mem_addr, 32'h8000_0000);
        checkOutput("t1_mwen", mem_wen, 32'd0);
        tick;
        s.mrv = 1'b1; s.mrd = 32'h0000_0413;
        applyStimulus(s);
        checkOutput("t1_mrespr", mem_resp_ready, 32'd1);
        tick;
        s.mrv = 1'b0; s.irr = 1'b1;
        applyStimulus(s);
        checkOutput("t1_ifu_respv", ifu_resp_valid, 32'd1);
        checkOutput("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        checkOutput("t1_lsu_respv", lsu_resp_valid, 32'd0);
        tick;
        s.irr = 1'b0;
        applyStimulus(s);
        checkOutput("t1_idle", arb_busy, 32'd0);

        // Simultaneous IFU fetch and LSU store: LSU served first
        s.iv = 1'b1; s.ia = 32'h8000_0004;
        s.lv = 1'b1; s.la = 32'h8000_1000; s.lw = 1'b1; s.ld = 32'hDEAD_BEEF; s.lm = 4'hF;
        s.mrq = 1'b1;
        applyStimulus(s);
        checkOutput("t2_lsu_rdy", lsu_req_ready, 32'd1);
        checkOutput("t2_ifu_rdy0", ifu_req_ready, 32'd0);
        tick;
        s.lv = 1'b0; s.lw = 1'b0;
        applyStimulus(s);
        checkOutput("t2_maddr", mem_addr, 32'h8000_1000);
        checkOutput("t2_mwen", mem_wen, 32'd1);
        checkOutput("t2_mwdata", mem_wdata, 32'hDEAD_BEEF);
        checkOutput("t2_mwmask", mem_wmask, 32'hF);
        checkOutput("t2_ifu_wait", ifu_req_ready, 32'd0);
        tick;
        s.mrv = 1'b1; s.mrd = 32'h0;
        applyStimulus(s);
        tick;
        s.mrv = 1'b0; s.lrr = 1'b1;
        applyStimulus(s);
        checkOutput("t2_lsu_respv", lsu_resp_valid, 32'd1);
        checkOutput("t2_ifu_respv", ifu_resp_valid, 32'd0);
        checkOutput("t2_ifu_hold", ifu_req_ready, 32'd0);
        tick;
        s.lrr = 1'b0; s.mrq = 1'b0;
        applyStimulus(s);
        checkOutput("t2_ifu_rdy", ifu_req_ready, 32'd1);
        tick;

        // Memory backpressure: payload held while mem_req_ready is low
        s.iv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkOutput("bp_mreqv", mem_req_valid, 32'd1);
            checkOutput("bp_maddr", mem_addr, 32'h8000_0004);
            checkOutput("bp_mwdata", mem_wdata, 32'd0);
            checkOutput("bp_mwmask", mem_wmask, 32'd0);
            tick;
        end
        s.mrq = 1'b1;
        applyStimulus(s);
        checkOutput("bp_mreqv_hs", mem_req_valid, 32'd1);
        tick;
        s.mrv = 1'b1; s.mrd = 32'h1234_5678;
        applyStimulus(s);
        tick;

        // Requester backpressure with a competing LSU load pending
        s.mrv = 1'b0; s.irr = 1'b0; s.lv = 1'b1; s.la = 32'h8000_2000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s);
            checkOutput("rb_ifu_respv", ifu_resp_valid, 32'd1);
            checkOutput("rb_ifu_rdata", ifu_rdata, 32'h1234_5678);
            checkOutput("rb_lsu_rdy", lsu_req_ready, 32'd0);
            tick;
        end
        s.irr = 1'b1;
        applyStimulus(s);
        checkOutput("rb_ifu_respv_hs", ifu_resp_valid, 32'd1);
        tick;
        s.irr = 1'b0;
        applyStimulus(s);
        checkOutput("rb_lsu_rdy_after", lsu_req_ready, 32'd1);
        tick;

        // Reset while the LSU load is waiting on memory
        s.lv = 1'b0; s.mrq = 1'b1;
        applyStimulus(s);
        checkOutput("rs_maddr_req", mem_addr, 32'h8000_2000);
        tick;
        s.mrq = 1'b0;
        applyStimulus(s);
        checkOutput("rs_wait", mem_resp_ready, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        applyStimulus(s);
        checkOutput("rs_busy", arb_busy, 32'd0);
        checkOutput("rs_mreqv", mem_req_valid, 32'd0);
        checkOutput("rs_mrespr", mem_resp_ready, 32'd0);
        checkOutput("rs_maddr", mem_addr, 32'd0);
        checkOutput("rs_rdata", lsu_rdata, 32'd0);
        s.mrv = 1'b1; s.mrd = 32'h0000_CAFE;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkOutput("rs_late_busy", arb_busy, 32'd0);
            checkOutput("rs_late_respv", {ifu_resp_valid, lsu_resp_valid}, 32'd0);
            tick;
        end

        // Both requesters continuously valid for four transactions
        s = '0;
        s.iv = 1'b1; s.ia = 32'h8000_0100; s.lv = 1'b1; s.la = 32'h8000_3000;
        s.mrq = 1'b1; s.mrv = 1'b1; s.irr = 1'b1; s.lrr = 1'b1;
        rst = 1'b1;
        applyStimulus(s);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(s);
            checkOutput($sformatf("rr_lsu_rdy%0d", k), lsu_req_ready, (!RR || (k % 2 == 0)) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr_ifu_rdy%0d", k), ifu_req_ready, (RR && (k % 2 == 1)) ? 32'd1 : 32'd0);
            repeat (4) tick;
        end

        // Randomized traffic against the transaction-level model
        s = '0;
        rst = 1'b1;
        applyStimulus(s);
        tick;
        rst = 1'b0;
        m_ifu_pend = 0; m_lsu_pend = 0; m_busy = 0; m_macc = 0; m_rpend = 0;
        m_own_lsu = 0; m_last_lsu = 0; mem_delay = 0; mem_data = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!m_ifu_pend && $urandom_range(0, 2) == 0) begin
                m_ifu_pend = 1;
                m_ifu_a = $urandom & 32'hFFFF_FFFC;
            end
            if (!m_lsu_pend && $urandom_range(0, 2) == 0) begin
                m_lsu_pend = 1;
                m_lsu_a = $urandom;
                m_lsu_w = 1'($urandom_range(0, 1));
                m_lsu_d = $urandom;
                m_lsu_m = 4'($urandom);
            end
            s.iv = m_ifu_pend; s.ia = m_ifu_a;
            s.lv = m_lsu_pend; s.la = m_lsu_a; s.lw = m_lsu_w; s.ld = m_lsu_d; s.lm = m_lsu_m;
            s.mrq = 1'($urandom_range(0, 1));
            s.mrv = m_busy && m_macc && !m_rpend && (mem_delay == 0);
            s.mrd = s.mrv ? mem_data : $urandom;
            s.irr = 1'($urandom_range(0, 1));
            s.lrr = 1'($urandom_range(0, 1));
            applyStimulus(s);

            grant   = !m_busy && (m_ifu_pend || m_lsu_pend);
            win_lsu = m_lsu_pend && (!m_ifu_pend || !RR || !m_last_lsu);
            checkOutput("r_ifu_rdy", ifu_req_ready, grant && !win_lsu);
            checkOutput("r_lsu_rdy", lsu_req_ready, grant && win_lsu);
            checkOutput("r_mreqv", mem_req_valid, m_busy && !m_macc);
            checkOutput("r_mrespr", mem_resp_ready, m_busy && m_macc && !m_rpend);
            checkOutput("r_ifu_respv", ifu_resp_valid, m_rpend && !m_own_lsu);
            checkOutput("r_lsu_respv", lsu_resp_valid, m_rpend && m_own_lsu);
            checkOutput("r_busy", arb_busy, m_busy);
            if (m_busy && !m_macc) begin
                checkOutput("r_maddr", mem_addr, e_addr);
                checkOutput("r_mwen", mem_wen, e_wen);
                checkOutput("r_mwdata", mem_wdata, e_wdata);
                checkOutput("r_mwmask", mem_wmask, e_wmask);
            end
            if (m_rpend) begin
                checkOutput("r_ifu_rdata", ifu_rdata, e_data);
                checkOutput("r_lsu_rdata", lsu_rdata, e_data);
            end

            if (m_rpend) begin
                if (m_own_lsu ? s.lrr : s.irr) begin
                    m_busy = 0; m_macc = 0; m_rpend = 0;
                end
            end else if (m_busy && m_macc) begin
                if (s.mrv) begin
                    m_rpend = 1;
                    e_data = mem_data;
                end else begin
                    mem_delay--;
                end
            end else if (m_busy) begin
                if (s.mrq) begin
                    m_macc = 1;
                    mem_delay = $urandom_range(0, 2);
                    mem_data = $urandom;
                end
            end else if (grant) begin
                m_busy = 1;
                m_own_lsu = win_lsu;
                m_last_lsu = win_lsu;
                if (win_lsu) begin
                    e_addr = m_lsu_a; e_wen = m_lsu_w; e_wdata = m_lsu_d; e_wmask = m_lsu_m;
                    m_lsu_pend = 0;
                end else begin
                    e_addr = m_ifu_a; e_wen = 0; e_wdata = '0; e_wmask = '0;
                    m_ifu_pend = 0;
                end
            end
            tick;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060042_mem_arb.md
Name: ysyx_23060042_mem_arb

Overview:
- Two-requester, single-outstanding arbiter that shares the core's one memory port between instruction fetch (IFU) and load/store (LSU).
- Serialises requests, holds the request payload stable toward memory, buffers the response, and returns it only to the owning requester.
- Sits between the IFU/LSU (which feeds `mrdata` to the execute stage) and the DPI-backed memory model.
- Replaces the current zero-latency memory read path once the core moves to multi-cycle execution.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; write mask width is DATA_W/8.

Ports:
- clk  in  1  core clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_resp_valid  out  1  fetch data available.
- ifu_resp_ready  in  1  IFU consumes the response.
- ifu_rdata  out  DATA_W  fetched word.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte enables.
- lsu_resp_valid  out  1  LSU response available.
- lsu_resp_ready  in  1  LSU consumes the response.
- lsu_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  registered payload.
- mem_resp_valid  in  1  memory response.
- mem_resp_ready  out  1  arbiter accepts the response.
- mem_rdata  in  DATA_W  memory read data.
- arb_busy  out  1  high when state is not IDLE.

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Exactly one transaction is outstanding at a time.
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All valid/ready outputs are 0; payload and response registers are 0; owner is IFU.
  - Reset mid-transaction aborts it; no response is delivered afterwards.
- IDLE:
  - If any req_valid is high, select the owner and assert that requester's req_ready combinationally in the same cycle.
  - Latch addr/wen/wdata/wmask and the owner, then go to REQ.
  - For IFU requests, wen=0 and wmask=0 are latched.
  - Fixed priority: LSU wins over IFU when both are valid.
- REQ: mem_req_valid=1 with the registered payload, held stable until mem_req_ready=1, then go to WAIT.
- WAIT:
  - mem_resp_ready=1.
  - On mem_resp_valid=1, capture mem_rdata into the response buffer and go to RESP.
  - A response arriving in the same cycle the request is accepted (REQ) is not sampled; memory must respond no earlier than the cycle after acceptance.
- RESP:
  - The owner's resp_valid=1 and its rdata = buffered data, held stable.
  - On the owner's resp_ready=1, go to IDLE. A new request is accepted no earlier than the next cycle.
- Non-owner:
  - Its req_ready and resp_valid stay 0 for the whole transaction.
  - Its request remains pending; requesters must hold valid and payload until ready.
- Stores complete through the full response phase; the LSU discards rdata.
- Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, response captured at cycle 2, resp_valid at cycle 3. Throughput is at most one transaction per 4 cycles.
- No combinational path from mem_* inputs to any requester output.
- ifu_rdata and lsu_rdata both drive the buffer value; validity is indicated only by resp_valid.

Optional Feature:
- Macro YSYX_23060042_MEM_ARB_RR_EN.
- Defined:
  - Round-robin on simultaneous requests; the previous owner loses the tie.
  - A last_grant register resets to IFU, so the first tie after reset grants LSU.
  - A lone request is always granted.
- Undefined: fixed LSU-over-IFU priority; no last_grant register is built.

Decomposition:
- Package ysyx_23060042_mem_arb_pkg:
  - state enum typedef (IDLE/REQ/WAIT/RESP).
  - owner enum (OWN_IFU, OWN_LSU).
  - packed request-payload struct (addr, wen, wdata, wmask).
- One sub-module, ysyx_23060042_mem_arb_sel: combinational grant selector.
  - Inputs: both req_valids and last_grant.
  - Outputs: grant owner and grant_valid.
  - Contains the RR logic under the macro.

Test Plan:
- Lone IFU fetch, addr 0x80000000, memory ready immediately, mem_rdata 0x00000413.
  - ifu_req_ready at cycle 0; mem_req_valid at cycle 1 with mem_addr 0x80000000, mem_wen 0.
  - ifu_resp_valid at cycle 3 with ifu_rdata 0x00000413; lsu_resp_valid stays 0.
- Simultaneous IFU (0x80000004) and LSU store (0x80001000, wdata 0xDEADBEEF, wmask 0xF), fixed priority.
  - LSU is served first with mem_wen 1 and mem_wmask 0xF.
  - IFU is accepted only after lsu_resp_ready, in the following IDLE cycle.
- Memory backpressure: mem_req_ready low for 3 cycles.
  - mem_addr, mem_wdata and mem_wmask stay constant and mem_req_valid stays high until the handshake.
- Requester backpressure: ifu_resp_ready low for 5 cycles.
  - ifu_resp_valid and ifu_rdata are held; a concurrent lsu_req_valid gets no lsu_req_ready until IFU consumes the response.
- Reset mid-transaction: rst=1 for 1 cycle while in WAIT.
  - All outputs read 0 and arb_busy is 0 next cycle; a late mem_resp_valid is ignored; no resp_valid to either requester.
- RR build: both requesters continuously valid for 4 transactions.
  - Grant order is LSU, IFU, LSU, IFU.
